// File: rtl/branch_predictor_if.sv
// branch_predictor_if: lookup, training and statistics bundle for branch_predictor; BP_GSHARE_EN adds the history signals
interface branch_predictor_if #(
  parameter int CRAM_ADDR_W = 15,
  parameter int STAT_W = 16
`ifdef BP_GSHARE_EN
  , parameter int HIST_W = 6
`endif
);
  logic ce, bp_enable, lookup_valid, take_flag, upd_valid, upd_taken, upd_pred, clear_stats;
  logic [CRAM_ADDR_W-1:0] lookup_pc, upd_pc;
  logic [STAT_W-1:0] o_lookup_count, o_mispredict_count;
`ifdef BP_GSHARE_EN
  logic [HIST_W-1:0] o_lookup_hist, upd_hist;
  modport master(output ce, bp_enable, lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken, upd_pred, clear_stats, upd_hist,
                 input take_flag, o_lookup_count, o_mispredict_count, o_lookup_hist);
  modport slave(input ce, bp_enable, lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken, upd_pred, clear_stats, upd_hist,
                output take_flag, o_lookup_count, o_mispredict_count, o_lookup_hist);
`else
  modport master(output ce, bp_enable, lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken, upd_pred, clear_stats,
                 input take_flag, o_lookup_count, o_mispredict_count);
  modport slave(input ce, bp_enable, lookup_valid, lookup_pc, upd_valid, upd_pc, upd_taken, upd_pred, clear_stats,
                output take_flag, o_lookup_count, o_mispredict_count);
`endif
endinterface

// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating-counter BHT with combinational lookup and saturating stats; BP_GSHARE_EN adds gshare history indexing
module branch_predictor #(
  parameter int CRAM_ADDR_W = 15,
  parameter int BHT_ENTRIES = 64,
  parameter int INDEX_LSB = 2,
  parameter logic [1:0] INIT_STATE = 2'b01,
  parameter int STAT_W = 16
) (
  input logic clk,
  input logic nrst,
  branch_predictor_if.slave bp
);
  localparam int IW = $clog2(BHT_ENTRIES);
  logic [1:0] ctr [BHT_ENTRIES];
  logic [IW-1:0] l_idx, u_idx;
  logic [STAT_W-1:0] lc, mc;
  logic upd;
  // PC bits outside the index field are intentionally ignored (untagged table)
  logic [CRAM_ADDR_W-1:0] unused_pc;
  assign unused_pc = bp.lookup_pc ^ bp.upd_pc;
  assign upd = bp.upd_valid & bp.ce;
`ifdef BP_GSHARE_EN
  logic [IW-1:0] ghr;
  assign l_idx = bp.lookup_pc[INDEX_LSB +: IW] ^ ghr;
  assign u_idx = bp.upd_pc[INDEX_LSB +: IW] ^ bp.upd_hist;
  assign bp.o_lookup_hist = ghr;
  // global history shifts in each registered branch outcome
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) ghr <= '0;
    else if (upd) ghr <= {ghr[IW-2:0], bp.upd_taken};
`else
  assign l_idx = bp.lookup_pc[INDEX_LSB +: IW];
  assign u_idx = bp.upd_pc[INDEX_LSB +: IW];
`endif
  // lookup reads the pre-update table, so a same-cycle update is not forwarded
  assign bp.take_flag = bp.bp_enable & bp.lookup_valid & ctr[l_idx][1];
  // saturating 2-bit counter training of the resolved branch's entry
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) for (int i = 0; i < BHT_ENTRIES; i++) ctr[i] <= INIT_STATE;
    else if (upd) ctr[u_idx] <= bp.upd_taken ? (&ctr[u_idx] ? 2'b11 : ctr[u_idx] + 2'b01)
                                             : (~|ctr[u_idx] ? 2'b00 : ctr[u_idx] - 2'b01);
  // debug statistics: saturating, clear wins over increment, frozen while halted
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      lc <= '0;
      mc <= '0;
    end else if (bp.ce) begin
      lc <= bp.clear_stats ? '0 : lc + STAT_W'(bp.lookup_valid && !(&lc));
      mc <= bp.clear_stats ? '0 : mc + STAT_W'(bp.upd_valid && (bp.upd_pred != bp.upd_taken) && !(&mc));
    end
  assign bp.o_lookup_count = lc;
  assign bp.o_mispredict_count = mc;
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: randomized and directed checks of branch_predictor against a behavioural table model
module tb_branch_predictor;
  localparam int SW = 8;
  localparam int MAXS = (1 << SW) - 1;
  logic clk, nrst;
  int pass_cnt, total_cnt;
  int m_ctr[64];
  int m_lc, m_mc, m_ghr;
  branch_predictor_if #(.CRAM_ADDR_W(15), .STAT_W(SW)
`ifdef BP_GSHARE_EN
    , .HIST_W(6)
`endif
  ) bif();
  branch_predictor #(.STAT_W(SW)) dut(.clk(clk), .nrst(nrst), .bp(bif));
  initial clk = 0;
  always #5 clk = ~clk;

  function automatic int midx(logic [14:0] pc, int hist);
    return ((int'(pc) >> 2) % 64) ^ hist;
  endfunction

  function automatic int cur_hist();
`ifdef BP_GSHARE_EN
    return m_ghr;
`else
    return 0;
`endif
  endfunction

  function automatic int upd_h();
`ifdef BP_GSHARE_EN
    return int'(bif.upd_hist);
`else
    return 0;
`endif
  endfunction

  function automatic logic model_take();
    return bif.bp_enable && bif.lookup_valid && (m_ctr[midx(bif.lookup_pc, cur_hist())] >= 2);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) m_ctr[i] = 1;
    m_lc = 0;
    m_mc = 0;
    m_ghr = 0;
  endtask

  task automatic set_idle();
    bif.ce = 1;
    bif.bp_enable = 1;
    bif.lookup_valid = 0;
    bif.lookup_pc = 0;
    bif.upd_valid = 0;
    bif.upd_pc = 0;
    bif.upd_taken = 0;
    bif.upd_pred = 0;
    bif.clear_stats = 0;
`ifdef BP_GSHARE_EN
    bif.upd_hist = 0;
`endif
  endtask

  task automatic tick();
    int i;
    if (bif.ce) begin
      if (bif.clear_stats) begin
        m_lc = 0;
        m_mc = 0;
      end else begin
        if (bif.lookup_valid && m_lc < MAXS) m_lc++;
        if (bif.upd_valid && bif.upd_pred != bif.upd_taken && m_mc < MAXS) m_mc++;
      end
      if (bif.upd_valid) begin
        i = midx(bif.upd_pc, upd_h());
        m_ctr[i] = bif.upd_taken ? (m_ctr[i] == 3 ? 3 : m_ctr[i] + 1) : (m_ctr[i] == 0 ? 0 : m_ctr[i] - 1);
        m_ghr = ((m_ghr << 1) | int'(bif.upd_taken)) % 64;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bif.lookup_valid = 1;
    bif.lookup_pc = 15'h0010;
    #1;
    total_cnt++;
    if (bif.take_flag !== 1'b0) $display("FAIL reset_take: got %b want 0", bif.take_flag); else pass_cnt++;
    total_cnt++;
    if (bif.o_lookup_count !== 0 || bif.o_mispredict_count !== 0)
      $display("FAIL reset_stats: got %0d/%0d want 0/0", bif.o_lookup_count, bif.o_mispredict_count);
    else pass_cnt++;
  endtask

  task automatic test_first_lookup();
    bif.lookup_valid = 1;
    bif.lookup_pc = 15'h0010;
    #1;
    total_cnt++;
    if (bif.take_flag !== 1'b0) $display("FAIL first_take: got %b want 0", bif.take_flag); else pass_cnt++;
    tick();
    total_cnt++;
    if (bif.o_lookup_count !== SW'(1)) $display("FAIL first_count: got %0d want 1", bif.o_lookup_count); else pass_cnt++;
    bif.lookup_valid = 0;
  endtask

  task automatic test_train_taken();
    logic exp_seq[3] = '{1'b0, 1'b1, 1'b1};
    bif.lookup_valid = 1;
    bif.lookup_pc = 15'h0010;
    bif.upd_valid = 1;
    bif.upd_pc = 15'h0010;
    bif.upd_taken = 1;
    bif.upd_pred = 0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total_cnt++;
      if (bif.take_flag !== exp_seq[k] || bif.take_flag !== model_take())
        $display("FAIL train_taken[%0d]: got %b want %b", k, bif.take_flag, exp_seq[k]);
      else pass_cnt++;
      tick();
    end
    bif.upd_valid = 0;
    bif.lookup_pc = 15'h0110;
    #1;
    total_cnt++;
    if (bif.take_flag !== 1'b1) $display("FAIL alias_take: got %b want 1", bif.take_flag); else pass_cnt++;
    bif.lookup_pc = 15'h0010;
  endtask

  task automatic test_train_not_taken();
    logic exp_seq[3] = '{1'b1, 1'b1, 1'b0};
    bif.lookup_valid = 1;
    bif.lookup_pc = 15'h0010;
    bif.upd_pc = 15'h0010;
    bif.upd_taken = 0;
    bif.upd_pred = 1;
    for (int k = 0; k < 3; k++) begin
      bif.upd_valid = (k < 2);
      #1;
      total_cnt++;
      if (bif.take_flag !== exp_seq[k] || bif.take_flag !== model_take())
        $display("FAIL train_not_taken[%0d]: got %b want %b", k, bif.take_flag, exp_seq[k]);
      else pass_cnt++;
      tick();
    end
    set_idle();
  endtask

  task automatic test_ce_freeze();
    int lc0, mc0;
    logic t0;
    bif.lookup_valid = 1;
    bif.lookup_pc = 15'h0010;
    #1;
    t0 = bif.take_flag;
    lc0 = int'(bif.o_lookup_count);
    mc0 = int'(bif.o_mispredict_count);
    bif.ce = 0;
    bif.upd_valid = 1;
    bif.upd_pc = 15'h0010;
    bif.upd_taken = 1;
    bif.upd_pred = 0;
    repeat (5) tick();
    #1;
    total_cnt++;
    if (bif.take_flag !== t0 || bif.take_flag !== model_take())
      $display("FAIL ce_freeze_take: got %b want %b", bif.take_flag, t0);
    else pass_cnt++;
    total_cnt++;
    if (int'(bif.o_lookup_count) != lc0 || int'(bif.o_mispredict_count) != mc0)
      $display("FAIL ce_freeze_stats: got %0d/%0d want %0d/%0d", bif.o_lookup_count, bif.o_mispredict_count, lc0, mc0);
    else pass_cnt++;
    set_idle();
  endtask

  task automatic test_bp_disable();
    bif.upd_valid = 1;
    bif.upd_pc = 15'h0020;
    bif.upd_taken = 1;
    repeat (2) tick();
    bif.upd_valid = 0;
    bif.lookup_valid = 1;
    bif.lookup_pc = 15'h0020;
    bif.bp_enable = 0;
    #1;
    total_cnt++;
    if (bif.take_flag !== 1'b0) $display("FAIL bp_disable: got %b want 0", bif.take_flag); else pass_cnt++;
    bif.bp_enable = 1;
    #1;
    total_cnt++;
    if (bif.take_flag !== model_take() || bif.take_flag !== 1'b1)
      $display("FAIL bp_enable: got %b want 1", bif.take_flag);
    else pass_cnt++;
    set_idle();
  endtask

  task automatic test_mispredict();
    bif.clear_stats = 1;
    tick();
    bif.clear_stats = 0;
    for (int k = 0; k < 5; k++) begin
      bif.upd_valid = 1;
      bif.upd_pc = 15'(k * 4 + 15'h0100);
      bif.upd_taken = k[0];
      bif.upd_pred = (k < 3) ? ~k[0] : k[0];
      tick();
    end
    bif.upd_valid = 0;
    total_cnt++;
    if (bif.o_mispredict_count !== SW'(3) || m_mc != 3)
      $display("FAIL mispredict_count: got %0d want 3", bif.o_mispredict_count);
    else pass_cnt++;
    bif.lookup_valid = 1;
    bif.upd_valid = 1;
    bif.upd_taken = 1;
    bif.upd_pred = 0;
    repeat (MAXS + 5) tick();
    total_cnt++;
    if (int'(bif.o_mispredict_count) != MAXS || int'(bif.o_lookup_count) != MAXS)
      $display("FAIL stat_saturate: got %0d/%0d want %0d/%0d", bif.o_lookup_count, bif.o_mispredict_count, MAXS, MAXS);
    else pass_cnt++;
    bif.clear_stats = 1;
    tick();
    total_cnt++;
    if (bif.o_mispredict_count !== '0 || bif.o_lookup_count !== '0)
      $display("FAIL clear_priority: got %0d/%0d want 0/0", bif.o_lookup_count, bif.o_mispredict_count);
    else pass_cnt++;
    set_idle();
  endtask

  task automatic test_random();
    int errs = 0;
    for (int k = 0; k < 400; k++) begin
      bif.ce = ($urandom_range(0, 7) != 0);
      bif.bp_enable = ($urandom_range(0, 9) != 0);
      bif.lookup_valid = $urandom_range(0, 1);
      bif.lookup_pc = 15'($urandom) & 15'h013C;
      bif.upd_valid = $urandom_range(0, 1);
      bif.upd_pc = 15'($urandom) & 15'h013C;
      bif.upd_taken = $urandom_range(0, 1);
      bif.upd_pred = $urandom_range(0, 1);
      bif.clear_stats = ($urandom_range(0, 31) == 0);
`ifdef BP_GSHARE_EN
      bif.upd_hist = 6'($urandom_range(0, 3));
`endif
      #1;
      total_cnt++;
      if (bif.take_flag !== model_take() || int'(bif.o_lookup_count) != m_lc || int'(bif.o_mispredict_count) != m_mc) begin
        if (errs < 5) $display("FAIL random[%0d]: got take=%b lc=%0d mc=%0d want take=%b lc=%0d mc=%0d",
                               k, bif.take_flag, bif.o_lookup_count, bif.o_mispredict_count, model_take(), m_lc, m_mc);
        errs++;
      end else pass_cnt++;
      tick();
    end
    set_idle();
  endtask

  task automatic test_async_reset();
    bif.upd_valid = 1;
    bif.upd_pc = 15'h0030;
    bif.upd_taken = 1;
    bif.upd_pred = 0;
    bif.lookup_valid = 1;
    repeat (3) tick();
    bif.upd_valid = 0;
    bif.lookup_pc = 15'h0030;
    #1;
    nrst = 0;
    model_reset();
    #1;
    total_cnt++;
    if (bif.take_flag !== 1'b0 || bif.o_lookup_count !== '0 || bif.o_mispredict_count !== '0)
      $display("FAIL async_reset: got take=%b lc=%0d mc=%0d want 0/0/0", bif.take_flag, bif.o_lookup_count, bif.o_mispredict_count);
    else pass_cnt++;
    #1;
    nrst = 1;
    @(posedge clk);
    #1;
    bif.lookup_valid = 0;
    tick();
    for (int i = 0; i < 64; i++) begin
      bif.lookup_valid = 1;
      bif.lookup_pc = 15'(i * 4);
      #1;
      total_cnt++;
      if (bif.take_flag !== 1'b0) $display("FAIL reset_entry[%0d]: got %b want 0", i, bif.take_flag); else pass_cnt++;
    end
    bif.lookup_valid = 0;
    bif.upd_valid = 1;
    bif.upd_pc = 15'h0030;
    bif.upd_taken = 1;
    tick();
    bif.upd_valid = 0;
    bif.lookup_valid = 1;
    bif.lookup_pc = 15'h0030;
    #1;
    total_cnt++;
    if (bif.take_flag !== 1'b1 || model_take() !== 1'b1)
      $display("FAIL init_state_step: got %b want 1", bif.take_flag);
    else pass_cnt++;
    set_idle();
    tick();
  endtask

`ifdef BP_GSHARE_EN
  task automatic test_gshare();
    nrst = 0;
    model_reset();
    #2;
    nrst = 1;
    @(posedge clk);
    #1;
    bif.upd_valid = 1;
    bif.upd_pc = 15'h0040;
    bif.upd_hist = 0;
    bif.upd_taken = 1;
    repeat (2) tick();
    bif.upd_valid = 0;
    bif.lookup_valid = 1;
    bif.lookup_pc = 15'h0040;
    #1;
    total_cnt++;
    if (int'(bif.o_lookup_hist) != m_ghr || m_ghr != 3)
      $display("FAIL gshare_ghr: got %0d want 3", bif.o_lookup_hist);
    else pass_cnt++;
    total_cnt++;
    if (bif.take_flag !== model_take() || bif.take_flag !== 1'b0)
      $display("FAIL gshare_index: got %b want 0", bif.take_flag);
    else pass_cnt++;
    set_idle();
  endtask
`endif

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    set_idle();
    model_reset();
    nrst = 0;
    #13;
    test_reset();
    bif.lookup_valid = 0;
    nrst = 1;
    @(posedge clk);
    #1;
    test_first_lookup();
    test_train_taken();
    test_train_not_taken();
    test_ce_freeze();
    test_bp_disable();
    test_mispredict();
    test_random();
    test_async_reset();
`ifdef BP_GSHARE_EN
    test_gshare();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
